// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment scan driver: active-high hex
// segment patterns, segment bit positions and the per-slot state encoding.
package seven_segment_pkg;

    // Segment bit positions within the 8-bit segment bus
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Active-high a..g patterns (bit0 = a) for hex digits 0..F
    localparam logic [6:0] HEX_SEGMENTS [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Per-slot phase: DEAD = all digits off, DRIVE = selected digit lit
    typedef enum logic {
        DEAD  = 1'b0,
        DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/seven_segment_decoder.sv
// Hex nibble plus decimal point to active-high segment pattern.
import seven_segment_pkg::*;

module seven_segment_decoder (
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] pattern
);

    // Table lookup for a..g, dp passed straight through
    always_comb begin
        pattern              = '0;
        pattern[SEG_G:SEG_A] = HEX_SEGMENTS[nibble];
        pattern[SEG_DP]      = dp;
    end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed, double-buffered driver for a DIGITS-digit seven-segment
// display with dead time between digit slots.
// Optional: define SEVEN_SEGMENT_LZB_EN to enable leading-zero blanking.
import seven_segment_pkg::*;

module seven_segment_mux #(
    parameter int DIGITS         = 4,
    parameter int CLK_HZ         = 50000000,
    parameter int REFRESH_HZ     = 1000,
    parameter int DEAD_CYCLES    = 16,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame_done
);

    localparam int DIV = CLK_HZ / REFRESH_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0]     PRE_LAST      = PW'(DIV - 1);
    localparam logic [PW-1:0]     PRE_DEAD_LAST = PW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
    localparam logic [IW-1:0]     IDX_LAST      = IW'(DIGITS - 1);
    localparam state_t            SLOT_START    = (DEAD_CYCLES > 0) ? DEAD : DRIVE;
    localparam logic [7:0]        SEG_OFF       = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_OFF       = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [PW-1:0]       pre;
    logic [IW-1:0]       index;
    state_t              state;
    logic                slot_end;
    logic                wrap;

    logic [4*DIGITS-1:0] act_value;
    logic [DIGITS-1:0]   act_dp;
    logic [DIGITS-1:0]   act_blank;
    logic [4*DIGITS-1:0] pend_value;
    logic [DIGITS-1:0]   pend_dp;
    logic [DIGITS-1:0]   pend_blank;
    logic                pend_valid;

    logic [DIGITS-1:0]   dark;
    logic [3:0]          cur_nibble;
    logic                cur_dp;
    logic                cur_dark;
    logic [7:0]          cur_pattern;

    // Slot end and frame wrap strobes
    always_comb begin
        slot_end = (pre == PRE_LAST);
        wrap     = slot_end && (index == IDX_LAST);
    end

    // Prescaler, digit index, slot phase and frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre        <= '0;
            index      <= '0;
            state      <= SLOT_START;
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            if (slot_end) begin
                pre   <= '0;
                index <= (index == IDX_LAST) ? '0 : index + IW'(1);
                state <= SLOT_START;
            end else begin
                pre <= pre + PW'(1);
                // State tracks the prescaler value being entered on this edge
                if ((DEAD_CYCLES > 0) && (pre == PRE_DEAD_LAST))
                    state <= DRIVE;
            end
        end
    end

    // Pending/active buffers; swap only at the frame boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_value  <= '0;
            act_dp     <= '0;
            act_blank  <= '0;
            pend_value <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_valid <= 1'b0;
        end else if (wrap) begin
            if (load) begin
                act_value  <= value;
                act_dp     <= dp_in;
                act_blank  <= blank;
                pend_valid <= 1'b0;
            end else if (pend_valid) begin
                act_value  <= pend_value;
                act_dp     <= pend_dp;
                act_blank  <= pend_blank;
                pend_valid <= 1'b0;
            end
        end else if (load) begin
            pend_value <= value;
            pend_dp    <= dp_in;
            pend_blank <= blank;
            pend_valid <= 1'b1;
        end
    end

`ifdef SEVEN_SEGMENT_LZB_EN
    // Explicit blank plus leading-zero blanking scanned from the top digit down
    always_comb begin
        logic run;
        dark = act_blank;
        run  = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            if (run && (act_value[4*k +: 4] == 4'h0) && !act_dp[k])
                dark[k] = 1'b1;
            run = run && dark[k];
        end
    end
`else
    // Only the explicit blank input darkens a digit
    always_comb begin
        dark = act_blank;
    end
`endif

    // Select the nibble, dp and blanking of the digit owning the current slot
    always_comb begin
        cur_nibble = '0;
        cur_dp     = 1'b0;
        cur_dark   = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (index == IW'(k)) begin
                cur_nibble = act_value[4*k +: 4];
                cur_dp     = act_dp[k];
                cur_dark   = dark[k];
            end
        end
    end

    seven_segment_decoder u_decoder (
        .nibble  (cur_nibble),
        .dp      (cur_dp),
        .pattern (cur_pattern)
    );

    // Registered pin drivers with polarity applied
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg    <= SEG_OFF;
            dig_en <= DIG_OFF;
        end else if (state == DRIVE) begin
            seg    <= (cur_dark ? 8'h00 : cur_pattern) ^ SEG_OFF;
            dig_en <= (DIGITS'(1) << index) ^ DIG_OFF;
        end else begin
            seg    <= SEG_OFF;
            dig_en <= DIG_OFF;
        end
    end

endmodule
